// File: rtl/multdiv_issue_pkg.sv
// Shared definitions for the mult/div issue controller.
// State encoding, default sizing and the nominal unit latency.
package multdiv_issue_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } mdState_t;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_TIMEOUT = 40;
  localparam int DEFAULT_CNT_W   = 6;
  localparam int MD_LATENCY      = 33;

endpackage

// File: rtl/multdiv_issue_watchdog.sv
// Watchdog counter for the WAIT state of the mult/div issue block.
// Flags the cycle in which the count sits at TIMEOUT-1.
module md_watchdog
  import multdiv_issue_pkg::*;
#(
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/multdiv_issue.sv
// Processor-side initiator for the iterative mult/div units.
// Latches a request, pulses start, waits for ready, presents writeback.
module multdiv_issue
  import multdiv_issue_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [4:0]       destReg,
  input  logic             wb_hold,
  input  logic             md_ready,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_exception,
  output logic             md_start,
  output logic             md_isDiv,
  output logic [WIDTH-1:0] md_opA,
  output logic [WIDTH-1:0] md_opB,
  output logic             stall,
  output logic             wb_valid,
  output logic [4:0]       wb_reg,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_exception
);

  mdState_t state;
  mdState_t nextState;

  logic request;
  logic divZero;
  logic loadReq;
  logic capReady;
  logic capTimeout;
  logic wdClear;
  logic wdEnable;
  logic wdTerminal;

  assign request = ctrl_MULT | ctrl_DIV;
  assign divZero = ctrl_DIV && (opB == '0);

  always_comb begin
    nextState  = state;
    loadReq    = 1'b0;
    capReady   = 1'b0;
    capTimeout = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (request) begin
          loadReq   = 1'b1;
          nextState = divZero ? S_DONE : S_START;
        end
      end
      S_START: nextState = S_WAIT;
      S_WAIT: begin
        // ready is only trusted here; in START it may be the previous op's level
        if (md_ready) begin
          capReady  = 1'b1;
          nextState = S_DONE;
        end else if (wdTerminal) begin
          capTimeout = 1'b1;
          nextState  = S_DONE;
        end
      end
      S_DONE: begin
        if (!wb_hold) nextState = S_IDLE;
      end
      default: nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      md_opA       <= '0;
      md_opB       <= '0;
      md_isDiv     <= 1'b0;
      wb_reg       <= '0;
      wb_data      <= '0;
      wb_exception <= 1'b0;
    end else if (loadReq) begin
      md_opA       <= opA;
      md_opB       <= opB;
      md_isDiv     <= ctrl_DIV;
      wb_reg       <= destReg;
      wb_data      <= '0;
      wb_exception <= divZero;
    end else if (capReady) begin
      wb_data      <= md_result;
      wb_exception <= md_exception;
    end else if (capTimeout) begin
      wb_data      <= '0;
      wb_exception <= 1'b1;
    end
  end

  assign wdClear  = (state == S_START);
  assign wdEnable = (state == S_WAIT) && !md_ready && !wdTerminal;

  md_watchdog #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wdClear),
    .enable  (wdEnable),
    .terminal(wdTerminal)
  );

  assign md_start = (state == S_START);
  assign wb_valid = (state == S_DONE);
  assign stall    = (state != S_IDLE) || request;

endmodule
